fix_real_const_div: RTL and testbench
=====================================

# fix_real_const_div

Sequential fixed-point divider by a compile-time constant: accepts an unsigned product-domain word `D` and returns `Q = floor(D·2^SHIFT / C)` plus the remainder. It uses restoring division, one quotient bit per clock. It is the inverse-direction companion of the constant-multiplier (KCM) datapath: it maps a scaled product back to the operand domain. It sits behind a valid/ready stream and feeds a valid/ready stream.

## Interface
Parameters:
- `W_D`, 10, input word width.
- `W_Q`, 8, output quotient width (saturating).
- `W_C`, 8, constant width.
- `C`, 5, divisor constant; unsigned, `1 ≤ C < 2^W_C`. Violation is an elaboration-time error.
- `SHIFT`, 0, extra fractional bits appended to `D` before division.

Ports:
- `clk`, in, 1, single clock; all state on rising edge.
- `rst_n`, in, 1, synchronous active-low reset.
- `in_valid`, in, 1, `D` valid.
- `in_ready`, out, 1, block can accept; high only in IDLE.
- `d`, in, `W_D`, dividend.
- `out_valid`, out, 1, result valid.
- `out_ready`, in, 1, consumer accepts result.
- `q`, out, `W_Q`, quotient, saturated.
- `rem`, out, `W_C`, true remainder, `0 ≤ rem < C`.
- `sat`, out, 1, quotient exceeded `2^W_Q − 1`.

## Operation
- `N = W_D + SHIFT` is both the iteration count and the numerator width. Internal quotient register is `N` bits; partial-remainder register is `W_C+1` bits.
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid & in_ready`: load numerator `{d, SHIFT zeros}`, clear partial remainder and quotient, clear the iteration counter, and go to RUN.
- **RUN:** each edge performs one step:
  - shift the numerator MSB into the partial remainder;
  - if partial remainder ≥ `C`, subtract `C` and shift in quotient bit 1, else shift in 0;
  - increment the counter.
  - After the N-th step, go to DONE.
- **DONE:**
  - `out_valid=1`.
  - Register the outputs at the RUN→DONE transition.
  - If any internal quotient bit ≥ `W_Q` is set: `q` is all-ones and `sat=1`.
  - Otherwise `q` = low `W_Q` bits and `sat=0`.
  - `rem` is always the exact remainder.
  - Outputs are held stable while `out_ready=0`.
  - On `out_valid & out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. No overlap: one operation in flight.
- Reset (`rst_n=0` at an edge), in any state including mid-RUN or DONE:
  - next state is IDLE;
  - `out_valid=0`, `q=0`, `rem=0`, `sat=0`;
  - the in-flight operation is discarded and never emitted.
  - `in_ready` reads 1 while in IDLE.
  - Inputs sampled while `rst_n=0` are ignored.

## Timing
- Accept edge `e0`. Iterations occur on edges `e1..eN`. `out_valid` is high after `eN`.
- Latency: `N` cycles from accept to `out_valid`. Default config: 10.
- Result handshake completes on edge `eK`. After `eK`, state is IDLE, `in_ready=1` and `out_valid=0`.
- Earliest next accept is the edge after `eK`.
- Max throughput with `out_ready` tied high: one result per `N+2` cycles.
- `in_ready` and `out_valid` are pure state decodes, registered-state based. No combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Package `fix_const_div_pkg`:
  - FSM state enum typedef (IDLE/RUN/DONE);
  - a `clog2`-based counter-width constant helper;
  - default width constants.
- Sub-module `fix_const_div_step`: purely combinational single restoring step.
  - Inputs: partial remainder, incoming bit, constant.
  - Outputs: next partial remainder, quotient bit.
- Top: FSM, counter, shift registers, saturation, and output registers.
- Estimated 150–250 lines total.

## Test plan
- `C=5`, `d=1000`, `out_ready=1` → `out_valid` exactly 10 cycles after accept; `q=200`, `rem=0`, `sat=0`. Next accept is possible 2 cycles later.
- `C=5`, `d=1023` → `q=204`, `rem=3`, `sat=0`. Also `d=0` → `q=0`, `rem=0`, `sat=0`.
- Instance `C=3`, `d=1023` → internal quotient 341 → `q=255`, `sat=1`, `rem=0`.
- `C=5`, `d=7`, `SHIFT=2` → numerator 28 → `q=5`, `rem=3`, latency 12.
- Backpressure:
  - Stimulus: hold `out_ready=0` for 5 cycles after `out_valid` while toggling `in_valid` with `d=500`.
  - Required: `q`/`rem`/`sat` stable, `in_ready=0`, no second operation. After `out_ready=1`, exactly one result (`q=100`) and then IDLE.
- Reset mid-operation:
  - Stimulus: `rst_n=0` at RUN iteration 4.
  - Required: after that edge, `out_valid=0`, `q=0`, `rem=0`, `sat=0`, state IDLE. No stale result appears. After release, a new `d=25` yields `q=5`, `rem=0`.

Source files
------------

// File: rtl/fix_const_div_pkg.sv
// Shared types and sizing helpers for the constant-divisor datapath.
package fix_const_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_W_D   = 10;
  localparam int DEF_W_Q   = 8;
  localparam int DEF_W_C   = 8;
  localparam int DEF_C     = 5;
  localparam int DEF_SHIFT = 0;

  // Width of a counter that must hold values 0..n.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fix_const_div_step.sv
// One restoring-division step: shift a numerator bit into the partial
// remainder and subtract the constant when it fits.
module fix_const_div_step #(
  parameter int W_C = 8
) (
  input  logic [W_C:0]   pr_in,
  input  logic           bit_in,
  input  logic [W_C-1:0] c,
  output logic [W_C:0]   pr_out,
  output logic           q_bit
);

  localparam int PW = W_C + 1;

  logic [W_C+1:0] shifted;

  always_comb begin
    shifted = {pr_in, bit_in};
    q_bit   = (shifted >= {2'b00, c});
    pr_out  = q_bit ? PW'(shifted - {2'b00, c}) : PW'(shifted);
  end

endmodule

// File: rtl/fix_real_const_div.sv
// Sequential divider by a compile-time constant: q = floor(d * 2^SHIFT / C),
// one quotient bit per clock, saturating quotient and exact remainder.
module fix_real_const_div
  import fix_const_div_pkg::*;
#(
  parameter int W_D   = DEF_W_D,
  parameter int W_Q   = DEF_W_Q,
  parameter int W_C   = DEF_W_C,
  parameter int C     = DEF_C,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W_D-1:0] d,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_Q-1:0] q,
  output logic [W_C-1:0] rem,
  output logic           sat,
  output logic [1:0]     dbg_state
);

  // Handshakes: a transfer happens on an edge where valid and ready are both
  // high; in_ready and out_valid decode only the registered state, so neither
  // depends combinationally on in_valid or out_ready.

  localparam int N  = W_D + SHIFT;
  localparam int CW = cnt_width(N);
  localparam logic [W_C-1:0] C_K  = W_C'(C);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  if (C < 1 || C >= (1 << W_C)) begin : g_bad_c
    $error("fix_real_const_div: divisor C must satisfy 1 <= C < 2^W_C");
  end

  state_e         state_q, state_d;
  logic [N-1:0]   num_q, num_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [W_C:0]   pr_q, pr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W_Q-1:0] q_q, q_d;
  logic [W_C-1:0] rem_q, rem_d;
  logic           sat_q, sat_d;

  logic [W_C:0]     pr_step;
  logic             q_bit;
  logic [N-1:0]     quo_step;
  logic [N+W_Q-1:0] quo_ext;
  logic             over;

  fix_const_div_step #(.W_C(W_C)) u_step (
    .pr_in  (pr_q),
    .bit_in (num_q[N-1]),
    .c      (C_K),
    .pr_out (pr_step),
    .q_bit  (q_bit)
  );

  // Zero-extend so the saturation test and the low slice work for any N vs W_Q.
  assign quo_step = (quo_q << 1) | N'(q_bit);
  assign quo_ext  = {{W_Q{1'b0}}, quo_step};
  assign over     = ((quo_ext >> W_Q) != '0);

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    quo_d   = quo_q;
    pr_d    = pr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          num_d   = N'(d) << SHIFT;
          quo_d   = '0;
          pr_d    = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        num_d = num_q << 1;
        pr_d  = pr_step;
        quo_d = quo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = ST_DONE;
          q_d     = over ? '1 : quo_ext[W_Q-1:0];
          rem_d   = pr_step[W_C-1:0];
          sat_d   = over;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      num_q   <= '0;
      quo_q   <= '0;
      pr_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      quo_q   <= quo_d;
      pr_q    <= pr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign q         = q_q;
  assign rem       = rem_q;
  assign sat       = sat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fix_real_const_div.sv
// Scoreboard bench for fix_real_const_div: three instances (C=5, C=3,
// C=5 with SHIFT=2) driven with hand-computed directed vectors.
module tb_fix_real_const_div;
  import fix_const_div_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       in_valid, in_ready, out_valid, out_ready, sat;
  logic [2:0][9:0]  d_v;
  logic [2:0][7:0]  q, rem;
  logic [2:0][1:0]  st;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [16:0] exp_q0[$];
  logic [16:0] exp_q1[$];
  logic [16:0] exp_q2[$];

  fix_real_const_div #(.W_D(10), .W_Q(8), .W_C(8), .C(5), .SHIFT(0)) u_c5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .d(d_v[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .q(q[0]), .rem(rem[0]), .sat(sat[0]), .dbg_state(st[0]));

  fix_real_const_div #(.W_D(10), .W_Q(8), .W_C(8), .C(3), .SHIFT(0)) u_c3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .d(d_v[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .q(q[1]), .rem(rem[1]), .sat(sat[1]), .dbg_state(st[1]));

  fix_real_const_div #(.W_D(10), .W_Q(8), .W_C(8), .C(5), .SHIFT(2)) u_c5s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .d(d_v[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .q(q[2]), .rem(rem[2]), .sat(sat[2]), .dbg_state(st[2]));

  function automatic logic [16:0] pk(input logic [7:0] qq, input logic [7:0] rr,
                                     input logic ss);
    return {qq, rr, ss};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [16:0] e);
    case (k)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // scoreboard monitor: pops one expectation per accepted result
  task automatic mon(input int k);
    logic [16:0] act;
    logic [16:0] e;
    int sz;
    act = {q[k], rem[k], sat[k]};
    case (k)
      0:       sz = exp_q0.size();
      1:       sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    if (sz == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_result_u%0d: got 0x%0h expected none", k, act);
    end else begin
      case (k)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      chk($sformatf("result_u%0d", k), 32'(act), 32'(e));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && out_ready[k]) mon(k);
      end
    end
  end

  // driver: issue one operation, check latency, optional backpressure hold
  task automatic op(input int k, input logic [9:0] dv, input logic [16:0] e,
                    input int hold);
    int lat;
    chk($sformatf("in_ready_before_u%0d", k), 32'(in_ready[k]), 32'd1);
    in_valid[k]  = 1'b1;
    d_v[k]       = dv;
    out_ready[k] = (hold == 0);
    push(k, e);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency_u%0d_d%0d", k, dv), 32'(lat), (k == 2) ? 32'd12 : 32'd10);
    for (int i = 0; i < hold; i++) begin
      chk($sformatf("hold_result_u%0d_c%0d", k, i), 32'({q[k], rem[k], sat[k]}), 32'(e));
      chk($sformatf("hold_in_ready_u%0d_c%0d", k, i), 32'(in_ready[k]), 32'd0);
      chk($sformatf("hold_out_valid_u%0d_c%0d", k, i), 32'(out_valid[k]), 32'd1);
      in_valid[k] = ~in_valid[k];
      d_v[k]      = 10'd500;
      @(posedge clk); #1;
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("post_out_valid_u%0d", k), 32'(out_valid[k]), 32'd0);
    chk($sformatf("post_in_ready_u%0d", k), 32'(in_ready[k]), 32'd1);
    chk($sformatf("post_state_u%0d", k), 32'(st[k]), 32'(ST_IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    in_valid  = '0;
    out_ready = '1;
    d_v       = '0;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_u%0d", k),
          32'({out_valid[k], in_ready[k], q[k], rem[k], sat[k]}),
          32'({1'b0, 1'b1, 8'd0, 8'd0, 1'b0}));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    op(0, 10'd1000, pk(8'd200, 8'd0, 1'b0), 0);
    op(0, 10'd1023, pk(8'd204, 8'd3, 1'b0), 0);
    op(0, 10'd0,    pk(8'd0,   8'd0, 1'b0), 0);

    op(1, 10'd1023, pk(8'd255, 8'd0, 1'b1), 0);
    op(1, 10'd768,  pk(8'd255, 8'd0, 1'b1), 0);
    op(1, 10'd767,  pk(8'd255, 8'd2, 1'b0), 0);

    op(2, 10'd7,    pk(8'd5,   8'd3, 1'b0), 0);
    op(2, 10'd63,   pk(8'd50,  8'd2, 1'b0), 0);
    op(2, 10'd1023, pk(8'd255, 8'd2, 1'b1), 0);

    op(0, 10'd500,  pk(8'd100, 8'd0, 1'b0), 5);

    // reset at RUN iteration 4: the in-flight operation must vanish
    in_valid[0] = 1'b1;
    d_v[0]      = 10'd1000;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_run_state", 32'(st[0]), 32'(ST_RUN));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset_outputs", 32'({out_valid[0], q[0], rem[0], sat[0]}), 32'd0);
    chk("mid_reset_state", 32'(st[0]), 32'(ST_IDLE));
    chk("mid_reset_in_ready", 32'(in_ready[0]), 32'd1);
    in_valid[0] = 1'b1;
    d_v[0]      = 10'd999;
    @(posedge clk); #1;
    chk("reset_ignores_input", 32'(st[0]), 32'(ST_IDLE));
    in_valid[0] = 1'b0;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("no_stale_result", 32'(out_valid[0]), 32'd0);
    op(0, 10'd25, pk(8'd5, 8'd0, 1'b0), 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queues_drained", 32'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
